// File: rtl/op_glyph_rom.sv
// Operator glyph store (+, -, x, /) with a random-access read port for the
// recognition comparator and a valid/ready row-streaming port for display.
module op_glyph_rom #(
  parameter int unsigned GLYPH_W    = 16,
  parameter int unsigned GLYPH_H    = 16,
  parameter int unsigned NUM_GLYPHS = 4,
  parameter string       INIT_FILE  = "",
  localparam int unsigned GI_W = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1,
  localparam int unsigned RI_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_en,
  input  logic [GI_W-1:0]    a_glyph,
  input  logic [RI_W-1:0]    a_row,
  output logic [GLYPH_W-1:0] a_data,
  output logic               a_valid,
  output logic               a_err,
  input  logic               s_start,
  input  logic [GI_W-1:0]    s_glyph,
  input  logic               s_mirror,
  input  logic               s_invert,
  input  logic               s_ready,
  output logic               s_busy,
  output logic               s_valid,
  output logic [GLYPH_W-1:0] s_data,
  output logic [RI_W-1:0]    s_row,
  output logic               s_last
);

  // Only the built-in 16x16 operator set is synthesised in this block;
  // any other geometry or an external image reads back as all-zero rows.
  localparam bit BUILTIN_OK = (INIT_FILE == "") && (GLYPH_W == 16) &&
                              (GLYPH_H == 16) && (NUM_GLYPHS <= 4);
  localparam logic [RI_W-1:0] LAST_ROW = RI_W'(GLYPH_H - 1);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  // Row word lookup; out-of-range glyph or row yields zero.
  function automatic logic [GLYPH_W-1:0] rom_word(input logic [GI_W-1:0] g,
                                                  input logic [RI_W-1:0] r);
    logic [15:0] w;
    int unsigned ri;
    w  = 16'h0000;
    ri = 32'(r);
    if (BUILTIN_OK && (32'(g) < NUM_GLYPHS) && (ri < GLYPH_H)) begin
      case (32'(g))
        0: w = (ri >= 6 && ri <= 8) ? 16'hFFFF : 16'h0380;
        1: w = (ri >= 6 && ri <= 8) ? 16'hFFFF : 16'h0000;
        2: w = (16'h8000 >> ri) | (16'h0001 << ri);
        3: begin
          if ((ri >= 1 && ri <= 3) || (ri >= 12 && ri <= 14)) w = 16'h0380;
          else if (ri >= 6 && ri <= 8)                        w = 16'hFFFF;
          else                                                w = 16'h0000;
        end
        default: w = 16'h0000;
      endcase
    end
    return GLYPH_W'(w);
  endfunction

  // Display transform: left-right flip first, then complement.
  function automatic logic [GLYPH_W-1:0] xform(input logic [GLYPH_W-1:0] w,
                                               input logic mir,
                                               input logic inv);
    logic [GLYPH_W-1:0] m;
    m = '0;
    for (int i = 0; i < GLYPH_W; i++) m[i] = mir ? w[GLYPH_W-1-i] : w[i];
    return inv ? ~m : m;
  endfunction

  logic            a_oob_c;
  logic [RI_W-1:0] row_nxt_c;

  assign a_oob_c   = (32'(a_glyph) >= NUM_GLYPHS) || (32'(a_row) >= GLYPH_H);
  assign row_nxt_c = RI_W'(s_row + 1'b1);

  // Port A: one registered read per request, error flagged with the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_data  <= '0;
      a_valid <= 1'b0;
      a_err   <= 1'b0;
    end else begin
      a_valid <= a_en;
      a_err   <= a_en & a_oob_c;
      if (a_en) a_data <= a_oob_c ? '0 : rom_word(a_glyph, a_row);
    end
  end

  state_t          state;
  logic [GI_W-1:0] g_q;
  logic            mir_q;
  logic            inv_q;

  // Port B streaming FSM; next row is prefetched on each handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      g_q     <= '0;
      mir_q   <= 1'b0;
      inv_q   <= 1'b0;
      s_busy  <= 1'b0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_row   <= '0;
      s_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_start) begin
            g_q    <= s_glyph;
            mir_q  <= s_mirror;
            inv_q  <= s_invert;
            s_busy <= 1'b1;
            state  <= FETCH;
          end
        end
        FETCH: begin
          s_data  <= xform(rom_word(g_q, RI_W'(0)), mir_q, inv_q);
          s_row   <= '0;
          s_last  <= (GLYPH_H == 1);
          s_valid <= 1'b1;
          state   <= STREAM;
        end
        STREAM: begin
          if (s_valid && s_ready) begin
            if (s_last) begin
              s_valid <= 1'b0;
              s_last  <= 1'b0;
              s_busy  <= 1'b0;
              state   <= IDLE;
            end else begin
              s_row  <= row_nxt_c;
              s_data <= xform(rom_word(g_q, row_nxt_c), mir_q, inv_q);
              s_last <= (row_nxt_c == LAST_ROW);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
